// File: rtl/nn_seq_pkg.sv
// Shared types and network geometry for the 49-37-4 layer sequencer.
// Also holds the weight ROM base-address helper used by the address generator.
package nn_seq_pkg;

  localparam int N_IN     = 49;
  localparam int N_HID    = 37;
  localparam int N_OUT    = 4;
  localparam int W_ADDR_W = 11;
  localparam int A_ADDR_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    ACCUM,
    WAIT,
    WRITE,
    DONE
  } seq_state_t;

  // Fan-in indexed by layer: 0 = hidden layer (reads inputs), 1 = output layer
  localparam logic [A_ADDR_W-1:0] FAN_IN [2] = '{A_ADDR_W'(N_IN), A_ADDR_W'(N_HID)};

  // Bias address of a neuron; its weights follow immediately after it
  function automatic logic [W_ADDR_W-1:0] neuron_base(input logic layer,
                                                      input logic [A_ADDR_W-1:0] neuron);
    logic [W_ADDR_W-1:0] n;
    n = W_ADDR_W'(neuron);
    if (layer)
      return W_ADDR_W'(N_HID * (N_IN + 1)) + n * W_ADDR_W'(N_HID + 1);
    else
      return n * W_ADDR_W'(N_IN + 1);
  endfunction

endpackage

// File: rtl/nn_weight_addr_gen.sv
// Registered weight ROM address: bias slot for the bias beat, base+1+k for weight k.
// Address is held at zero whenever no read is issued.
module nn_weight_addr_gen
  import nn_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                is_bias,
  input  logic                layer,
  input  logic [A_ADDR_W-1:0] neuron,
  input  logic [A_ADDR_W-1:0] k,
  output logic [W_ADDR_W-1:0] w_addr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      w_addr <= '0;
    else if (en)
      w_addr <= neuron_base(layer, neuron) +
                (is_bias ? W_ADDR_W'(0) : W_ADDR_W'(k) + W_ADDR_W'(1));
    else
      w_addr <= '0;
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks every neuron of the 49-37-4 network through the shared neuron unit:
// bias beat, fan-in weight/activation beats, wait for the result, then write it back.
module nn_layer_sequencer
  import nn_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                w_rd_en,
  output logic [W_ADDR_W-1:0] w_addr,
  output logic                act_rd_en,
  output logic                act_sel,
  output logic [A_ADDR_W-1:0] act_addr,
  output logic                mac_valid,
  output logic                mac_first,
  output logic                mac_last,
  input  logic                nu_done,
  output logic                hid_we,
  output logic [A_ADDR_W-1:0] hid_waddr,
  output logic                out_we,
  output logic [1:0]          out_idx
);

  seq_state_t          state;
  logic                layer;
  logic [A_ADDR_W-1:0] neuron;
  logic [A_ADDR_W-1:0] k;
  logic [A_ADDR_W-1:0] last_k;
  logic                iss_bias;
  logic                iss_last;

  logic                req_w;
  logic                req_act;
  logic                req_bias;
  logic                req_last;
  logic                req_layer;
  logic [A_ADDR_W-1:0] req_neuron;
  logic [A_ADDR_W-1:0] req_k;

  assign last_k = FAN_IN[layer] - A_ADDR_W'(1);

  // Decide what read, if any, goes out next cycle so every strobe can be registered
  always_comb begin
    req_w      = 1'b0;
    req_act    = 1'b0;
    req_bias   = 1'b0;
    req_layer  = layer;
    req_neuron = neuron;
    req_k      = '0;
    if (!abort) begin
      case (state)
        IDLE: if (start) begin
          req_w      = 1'b1;
          req_bias   = 1'b1;
          req_layer  = 1'b0;
          req_neuron = '0;
        end
        BIAS: begin
          req_w   = 1'b1;
          req_act = 1'b1;
        end
        ACCUM: if (k != last_k) begin
          req_w   = 1'b1;
          req_act = 1'b1;
          req_k   = k + A_ADDR_W'(1);
        end
        WRITE: if (!(layer && (neuron == A_ADDR_W'(N_OUT - 1)))) begin
          req_w    = 1'b1;
          req_bias = 1'b1;
          if (!layer && (neuron == A_ADDR_W'(N_HID - 1))) begin
            req_layer  = 1'b1;
            req_neuron = '0;
          end else begin
            req_neuron = neuron + A_ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
    req_last = req_act && (req_k == last_k);
  end

  nn_weight_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (req_w),
    .is_bias (req_bias),
    .layer   (req_layer),
    .neuron  (req_neuron),
    .k       (req_k),
    .w_addr  (w_addr)
  );

  // mac_* trail the read strobes by one cycle, matching the ROM/buffer latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      layer     <= 1'b0;
      neuron    <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_rd_en   <= 1'b0;
      act_rd_en <= 1'b0;
      act_sel   <= 1'b0;
      act_addr  <= '0;
      iss_bias  <= 1'b0;
      iss_last  <= 1'b0;
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
      hid_we    <= 1'b0;
      hid_waddr <= '0;
      out_we    <= 1'b0;
      out_idx   <= '0;
    end else begin
      w_rd_en   <= req_w;
      act_rd_en <= req_act;
      act_sel   <= req_act & req_layer;
      act_addr  <= req_act ? req_k : '0;
      iss_bias  <= req_bias;
      iss_last  <= req_last;
      mac_valid <= w_rd_en & ~abort;
      mac_first <= iss_bias & ~abort;
      mac_last  <= iss_last & ~abort;
      hid_we    <= 1'b0;
      hid_waddr <= '0;
      out_we    <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        busy   <= 1'b0;
        layer  <= 1'b0;
        neuron <= '0;
        k      <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state  <= BIAS;
            busy   <= 1'b1;
            layer  <= 1'b0;
            neuron <= '0;
          end
          BIAS: begin
            state <= ACCUM;
            k     <= '0;
          end
          ACCUM: begin
            if (k == last_k) state <= WAIT;
            else             k     <= k + A_ADDR_W'(1);
          end
          WAIT: if (nu_done) begin
            state <= WRITE;
            if (layer) begin
              out_we  <= 1'b1;
              out_idx <= neuron[1:0];
            end else begin
              hid_we    <= 1'b1;
              hid_waddr <= neuron;
            end
          end
          WRITE: begin
            if (req_w) begin
              state  <= BIAS;
              layer  <= req_layer;
              neuron <= req_neuron;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
